// File: rtl/btb_bht_assoc.sv
// N-way set-associative branch target buffer with per-entry saturating direction counters.
// Lookup is combinational on the IF PC; the resolved EX branch updates the table and the statistics.
module btb_bht_assoc #(
   parameter int INDEX_LEN = 4,
   parameter int WAYS      = 2,
   parameter int CNT_BITS  = 2,
   parameter int STAT_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       PC_IF,
   output logic              find,
   output logic              jmp,
   output logic [31:0]       NPC_Pred,
   input  logic              ex_valid,
   input  logic              is_br_EX,
   input  logic              br_EX,
   input  logic [31:0]       PC_EX,
   input  logic [31:0]       br_target,
   input  logic              find_EX,
   input  logic [31:0]       NPC_Pred_EX,
   output logic              fail,
   output logic [STAT_W-1:0] br_count,
   output logic [STAT_W-1:0] mispred_count
);

   localparam int SETS  = 1 << INDEX_LEN;
   localparam int TAG_W = 30 - INDEX_LEN;
   localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
   localparam logic [CNT_BITS-1:0] CNT_WEAK = CNT_BITS'(1 << (CNT_BITS - 1));

   logic [WAYS-1:0]     r_valid  [SETS];
   logic [TAG_W-1:0]    r_tag    [SETS][WAYS];
   logic [31:0]         r_target [SETS][WAYS];
   logic [CNT_BITS-1:0] r_cnt    [SETS][WAYS];
   logic [WW-1:0]       r_rr     [SETS];
   logic                r_fail;
   logic [STAT_W-1:0]   r_br_count;
   logic [STAT_W-1:0]   r_mis_count;

   logic [INDEX_LEN-1:0] w_if_idx, w_ex_idx;
   logic [TAG_W-1:0]     w_if_tag, w_ex_tag;
   logic                 w_if_hit, w_ex_hit;
   logic [WW-1:0]        w_if_way, w_ex_way;
   logic                 w_inv_found;
   logic [WW-1:0]        w_inv_way;
   logic [WW-1:0]        w_vict_way;
   logic [WW-1:0]        w_rr_next;
   logic [CNT_BITS-1:0]  w_cnt_cur, w_cnt_next;
   logic [31:0]          w_actual_npc;
   logic                 w_mis;
   logic                 w_unused_ok;

   assign w_if_idx = PC_IF[INDEX_LEN+1:2];
   assign w_if_tag = PC_IF[31:INDEX_LEN+2];
   assign w_ex_idx = PC_EX[INDEX_LEN+1:2];
   assign w_ex_tag = PC_EX[31:INDEX_LEN+2];

   // Descending scans so the lowest-numbered matching way is the one left standing.
   always_comb begin
      w_if_hit = 1'b0;
      w_if_way = '0;
      w_ex_hit = 1'b0;
      w_ex_way = '0;
      w_inv_found = 1'b0;
      w_inv_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (r_valid[w_if_idx][w] && (r_tag[w_if_idx][w] == w_if_tag)) begin
            w_if_hit = 1'b1;
            w_if_way = WW'(w);
         end
         if (r_valid[w_ex_idx][w] && (r_tag[w_ex_idx][w] == w_ex_tag)) begin
            w_ex_hit = 1'b1;
            w_ex_way = WW'(w);
         end
         if (!r_valid[w_ex_idx][w]) begin
            w_inv_found = 1'b1;
            w_inv_way = WW'(w);
         end
      end
   end

   assign find     = w_if_hit;
   assign jmp      = w_if_hit && r_cnt[w_if_idx][w_if_way][CNT_BITS-1];
   assign NPC_Pred = jmp ? r_target[w_if_idx][w_if_way] : PC_IF + 32'd4;

   assign w_actual_npc = (is_br_EX && br_EX) ? br_target : PC_EX + 32'd4;
   assign w_mis        = (NPC_Pred_EX != w_actual_npc);

   assign w_vict_way = w_inv_found ? w_inv_way : r_rr[w_ex_idx];
   assign w_rr_next  = (r_rr[w_ex_idx] == WW'(WAYS - 1)) ? '0 : r_rr[w_ex_idx] + 1'b1;

   assign w_cnt_cur = r_cnt[w_ex_idx][w_ex_way];
   always_comb begin
      w_cnt_next = w_cnt_cur;
      if (br_EX) begin
         if (w_cnt_cur != CNT_MAX) w_cnt_next = w_cnt_cur + 1'b1;
      end else begin
         if (w_cnt_cur != '0) w_cnt_next = w_cnt_cur - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_rr[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               r_tag[s][w] <= '0;
               r_target[s][w] <= '0;
               r_cnt[s][w] <= '0;
            end
         end
         r_fail <= 1'b0;
         r_br_count <= '0;
         r_mis_count <= '0;
      end else if (ex_valid) begin
         r_fail <= w_mis;
         r_br_count <= r_br_count + STAT_W'(is_br_EX);
         r_mis_count <= r_mis_count + STAT_W'(w_mis);
         if (is_br_EX) begin
            if (w_ex_hit) begin
               r_cnt[w_ex_idx][w_ex_way] <= w_cnt_next;
               if (br_EX) r_target[w_ex_idx][w_ex_way] <= br_target;
            end else if (br_EX) begin
               r_valid[w_ex_idx][w_vict_way] <= 1'b1;
               r_tag[w_ex_idx][w_vict_way] <= w_ex_tag;
               r_target[w_ex_idx][w_vict_way] <= br_target;
               r_cnt[w_ex_idx][w_vict_way] <= CNT_WEAK;
               // Round-robin only advances when a live entry is displaced.
               if (!w_inv_found) r_rr[w_ex_idx] <= w_rr_next;
            end
         end else if (w_ex_hit) begin
            r_valid[w_ex_idx][w_ex_way] <= 1'b0;
         end
      end else begin
         r_fail <= 1'b0;
      end
   end

   assign fail          = r_fail;
   assign br_count      = r_br_count;
   assign mispred_count = r_mis_count;

   // find_EX is debug-only, and the byte-offset PC bits never address the table.
   assign w_unused_ok = ^{find_EX, PC_IF[1:0], PC_EX[1:0]};

endmodule

// File: tb/tb_btb_bht_assoc.sv
// Randomized and directed bench for btb_bht_assoc (INDEX_LEN=2, WAYS=2, CNT_BITS=2) against an
// entry-list reference model.
module tb_btb_bht_assoc;

   localparam int NSETS = 4;
   localparam int NWAYS = 2;

   logic        clk;
   logic        rst_n;
   logic [31:0] PC_IF;
   logic        find;
   logic        jmp;
   logic [31:0] NPC_Pred;
   logic        ex_valid;
   logic        is_br_EX;
   logic        br_EX;
   logic [31:0] PC_EX;
   logic [31:0] br_target;
   logic        find_EX;
   logic [31:0] NPC_Pred_EX;
   logic        fail;
   logic [31:0] br_count;
   logic [31:0] mispred_count;

   btb_bht_assoc #(
      .INDEX_LEN(2),
      .WAYS     (2),
      .CNT_BITS (2),
      .STAT_W   (32)
   ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .PC_IF        (PC_IF),
      .find         (find),
      .jmp          (jmp),
      .NPC_Pred     (NPC_Pred),
      .ex_valid     (ex_valid),
      .is_br_EX     (is_br_EX),
      .br_EX        (br_EX),
      .PC_EX        (PC_EX),
      .br_target    (br_target),
      .find_EX      (find_EX),
      .NPC_Pred_EX  (NPC_Pred_EX),
      .fail         (fail),
      .br_count     (br_count),
      .mispred_count(mispred_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_err;

   // Reference model: a list of entries per set, identified by the full PC above the index.
   bit          m_valid [NSETS][NWAYS];
   logic [31:0] m_pctag [NSETS][NWAYS];
   logic [31:0] m_tgt   [NSETS][NWAYS];
   int          m_cnt   [NSETS][NWAYS];
   int          m_rr    [NSETS];
   bit          m_fail;
   int unsigned m_br;
   int unsigned m_mis;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int m_set(input logic [31:0] pc);
      return int'((pc >> 2) % NSETS);
   endfunction

   function automatic int m_find(input logic [31:0] pc);
      int s = m_set(pc);
      for (int w = 0; w < NWAYS; w++)
         if (m_valid[s][w] && m_pctag[s][w] == (pc >> 4)) return w;
      return -1;
   endfunction

   function automatic bit m_taken(input logic [31:0] pc);
      int w = m_find(pc);
      return (w >= 0) && (m_cnt[m_set(pc)][w] >= 2);
   endfunction

   function automatic logic [31:0] m_npc(input logic [31:0] pc);
      if (m_taken(pc)) return m_tgt[m_set(pc)][m_find(pc)];
      return pc + 32'd4;
   endfunction

   task automatic m_reset();
      for (int s = 0; s < NSETS; s++) begin
         m_rr[s] = 0;
         for (int w = 0; w < NWAYS; w++) begin
            m_valid[s][w] = 0;
            m_pctag[s][w] = 0;
            m_tgt[s][w] = 0;
            m_cnt[s][w] = 0;
         end
      end
      m_fail = 0;
      m_br = 0;
      m_mis = 0;
   endtask

   task automatic m_update(input bit v, input bit isbr, input bit br, input logic [31:0] pcex,
                           input logic [31:0] tgt, input logic [31:0] npcex);
      logic [31:0] actual;
      bit mis;
      int s, w, slot;
      if (!v) begin
         m_fail = 0;
         return;
      end
      actual = (isbr && br) ? tgt : pcex + 32'd4;
      mis = (npcex != actual);
      m_fail = mis;
      m_br += isbr;
      m_mis += mis;
      s = m_set(pcex);
      w = m_find(pcex);
      if (isbr) begin
         if (w >= 0) begin
            if (br) begin
               m_cnt[s][w] = (m_cnt[s][w] + 1 > 3) ? 3 : m_cnt[s][w] + 1;
               m_tgt[s][w] = tgt;
            end else begin
               m_cnt[s][w] = (m_cnt[s][w] - 1 < 0) ? 0 : m_cnt[s][w] - 1;
            end
         end else if (br) begin
            slot = -1;
            for (int k = NWAYS - 1; k >= 0; k--) if (!m_valid[s][k]) slot = k;
            if (slot < 0) begin
               slot = m_rr[s];
               m_rr[s] = (m_rr[s] + 1) % NWAYS;
            end
            m_valid[s][slot] = 1;
            m_pctag[s][slot] = pcex >> 4;
            m_tgt[s][slot] = tgt;
            m_cnt[s][slot] = 2;
         end
      end else if (w >= 0) begin
         m_valid[s][w] = 0;
      end
   endtask

   // Called just after a posedge; returns just after the next posedge.
   task automatic step(input logic [31:0] ifpc, input bit v, input bit isbr, input bit br,
                       input logic [31:0] pcex, input logic [31:0] tgt, input logic [31:0] npcex);
      PC_IF = ifpc;
      ex_valid = v;
      is_br_EX = isbr;
      br_EX = br;
      PC_EX = pcex;
      br_target = tgt;
      NPC_Pred_EX = npcex;
      find_EX = $urandom_range(0, 1);
      @(negedge clk);
      check("find", find, m_find(ifpc) >= 0);
      check("jmp", jmp, m_taken(ifpc));
      check("npc_pred", NPC_Pred, m_npc(ifpc));
      @(posedge clk);
      #1;
      m_update(v, isbr, br, pcex, tgt, npcex);
      check("fail", fail, m_fail);
      check("br_count", br_count, m_br);
      check("mispred_count", mispred_count, m_mis);
   endtask

   task automatic probe(input logic [31:0] pc, input bit e_find, input bit e_jmp,
                        input logic [31:0] e_npc);
      PC_IF = pc;
      ex_valid = 1'b0;
      #1;
      check("probe_find", find, e_find);
      check("probe_jmp", jmp, e_jmp);
      check("probe_npc", NPC_Pred, e_npc);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      ex_valid = 1'b0;
      PC_IF = 32'h100;
      #1;
      m_reset();
      check("rst_find", find, 1'b0);
      check("rst_jmp", jmp, 1'b0);
      check("rst_npc", NPC_Pred, 32'h104);
      check("rst_fail", fail, 1'b0);
      check("rst_br", br_count, 32'd0);
      check("rst_mis", mispred_count, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_pc();
      return 32'h100 + ($urandom_range(0, 3) << 4) + ($urandom_range(0, 3) << 2);
   endfunction

   initial begin
      logic [31:0] pc_a, pc_b;
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      PC_IF = 32'h0;
      ex_valid = 1'b0;
      is_br_EX = 1'b0;
      br_EX = 1'b0;
      PC_EX = 32'h0;
      br_target = 32'h0;
      find_EX = 1'b0;
      NPC_Pred_EX = 32'h0;
      m_reset();
      do_reset();

      // Cold taken branch allocates weakly taken.
      step(32'h0, 1, 1, 1, 32'h100, 32'h200, 32'h104);
      check("cold_fail", fail, 1'b1);
      check("cold_mis", mispred_count, 32'd1);
      probe(32'h100, 1, 1, 32'h200);

      // Hysteresis and saturation.
      step(32'h100, 1, 1, 0, 32'h100, 32'h200, 32'h200);
      probe(32'h100, 1, 0, 32'h104);
      step(32'h100, 1, 1, 1, 32'h100, 32'h200, 32'h104);
      step(32'h100, 1, 1, 1, 32'h100, 32'h200, 32'h200);
      step(32'h100, 1, 1, 1, 32'h100, 32'h200, 32'h200);
      check("sat_nofail", fail, 1'b0);
      step(32'h100, 1, 1, 0, 32'h100, 32'h200, 32'h200);
      probe(32'h100, 1, 1, 32'h200);
      step(32'h100, 1, 1, 0, 32'h100, 32'h200, 32'h200);
      probe(32'h100, 1, 0, 32'h104);

      // Conflict and round-robin replacement in set 0.
      do_reset();
      step(32'h0, 1, 1, 1, 32'h100, 32'h300, 32'h104);
      step(32'h0, 1, 1, 1, 32'h110, 32'h310, 32'h114);
      step(32'h0, 1, 1, 1, 32'h120, 32'h320, 32'h124);
      probe(32'h100, 0, 0, 32'h104);
      probe(32'h110, 1, 1, 32'h310);
      probe(32'h120, 1, 1, 32'h320);
      step(32'h0, 1, 1, 1, 32'h130, 32'h330, 32'h134);
      probe(32'h110, 0, 0, 32'h114);
      probe(32'h120, 1, 1, 32'h320);

      // Bubble leaves the entry alone; a real non-branch alias invalidates it.
      do_reset();
      step(32'h0, 1, 1, 1, 32'h100, 32'h200, 32'h104);
      step(32'h100, 0, 0, 0, 32'h100, 32'h0, 32'h200);
      check("bubble_fail", fail, 1'b0);
      check("bubble_mis", mispred_count, 32'd1);
      probe(32'h100, 1, 1, 32'h200);
      step(32'h100, 1, 0, 0, 32'h100, 32'h0, 32'h200);
      check("alias_fail", fail, 1'b1);
      check("alias_mis", mispred_count, 32'd2);
      probe(32'h100, 0, 0, 32'h104);

      // Randomized traffic; EX prediction usually mirrors what IF would have predicted.
      for (int i = 0; i < 400; i++) begin
         pc_a = rand_pc();
         pc_b = rand_pc();
         step(pc_a, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 80,
              $urandom_range(0, 1), pc_b, 32'h1000 + ($urandom_range(0, 255) << 2),
              ($urandom_range(0, 99) < 70) ? m_npc(pc_b) : 32'h1000 + ($urandom_range(0, 15) << 2));
      end

      // Asynchronous reset between edges with a populated table and fail asserted.
      step(32'h0, 1, 1, 1, 32'h1f0, 32'h400, 32'h1f4);
      probe(32'h1f0, 1, 1, 32'h400);
      check("pre_rst_fail", fail, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_find", find, 1'b0);
      check("arst_jmp", jmp, 1'b0);
      check("arst_npc", NPC_Pred, 32'h1f4);
      check("arst_fail", fail, 1'b0);
      check("arst_br", br_count, 32'd0);
      check("arst_mis", mispred_count, 32'd0);
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step(32'h1f0, 1, 1, 1, 32'h1f0, 32'h400, 32'h1f4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/btb_bht_assoc.md
Name: btb_bht_assoc

Overview:
- Parametrised successor to the direct-mapped 1-bit BTB, for the 5-stage pipeline's IF/EX branch prediction path.
- Organised as an N-way set-associative target buffer with a per-entry CNT_BITS saturating direction counter (BHT) and round-robin replacement per set.
- Lookup is combinational on the IF-stage PC. Update and the mispredict flag are driven by the resolved branch in EX.
- Adds EX-slot validity qualification and branch/mispredict statistics counters.

Parameters:
INDEX_LEN, 4, set index bits; SETS = 2^INDEX_LEN, index = PC[INDEX_LEN+1:2]
WAYS, 2, associativity (1..8); WAYS=1 gives direct-mapped
CNT_BITS, 2, direction counter width (1..3)
STAT_W, 32, statistics counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
PC_IF  in  32  IF-stage PC
find  out  1  IF PC hits a valid entry
jmp  out  1  predict taken
NPC_Pred  out  32  predicted next PC
ex_valid  in  1  EX slot holds a real instruction (0 = bubble/stall; no update, no fail)
is_br_EX  in  1  EX instruction is a conditional branch
br_EX  in  1  EX branch resolved taken
PC_EX  in  32  EX-stage PC
br_target  in  32  resolved taken target
find_EX  in  1  IF-time find, piped to EX
NPC_Pred_EX  in  32  IF-time NPC_Pred, piped to EX
fail  out  1  registered: EX instruction was mispredicted
br_count  out  STAT_W  branches resolved
mispred_count  out  STAT_W  mispredictions

Behaviour:
- Entry fields: valid, tag = PC[31:INDEX_LEN+2], target[31:0], cnt[CNT_BITS-1:0]. Each set also holds a rr pointer of clog2(WAYS) bits (0 width when WAYS=1).
- Lookup (combinational):
  - hit = valid && tag match in any way of set PC_IF[INDEX_LEN+1:2]; lowest matching way wins.
  - find = hit; jmp = hit && cnt[CNT_BITS-1].
  - NPC_Pred = jmp ? target : PC_IF+4 (32-bit wrap).
- EX match: re-match PC_EX against its set the same way to give ex_hit and ex_way (from current contents, not from find_EX).
- actual_npc = (is_br_EX && br_EX) ? br_target : PC_EX+4.
- fail (register):
  - fail <= ex_valid && (NPC_Pred_EX != actual_npc).
  - fail <= 0 when ex_valid=0.
  - One-cycle latency: fail is high in the cycle after the EX cycle.
- Updates at posedge, only when ex_valid=1:
  - is_br_EX=1, ex_hit=1: cnt saturating +1 if br_EX, -1 otherwise (clamps at 2^CNT_BITS-1 and 0); target <= br_target if br_EX. Tag and rr unchanged.
  - is_br_EX=1, ex_hit=0, br_EX=1: allocate the lowest-numbered invalid way; if none, use the way at rr. Write valid=1, tag, target=br_target, cnt=2^(CNT_BITS-1) (weakly taken). rr <= (rr+1) mod WAYS only when a valid entry was evicted.
  - is_br_EX=1, ex_hit=0, br_EX=0: no allocation.
  - is_br_EX=0, ex_hit=1 (alias/stale entry): valid <= 0 for that way.
  - is_br_EX=0, ex_hit=0: nothing.
- Statistics, when ex_valid=1:
  - br_count += is_br_EX.
  - mispred_count += (NPC_Pred_EX != actual_npc).
  - Both wrap modulo 2^STAT_W; mispred_count and fail are always consistent.
- Same cycle IF read and EX write to the same entry: IF sees pre-edge contents, no bypass.
- Reset (async, rst_n=0):
  - All valid=0, cnt=0, tag=0, target=0, rr=0, fail=0, br_count=0, mispred_count=0.
  - Outputs during reset: find=0, jmp=0, NPC_Pred=PC_IF+4.
  - Reset mid-update aborts the write. First update is at the first posedge after rst_n rises.
- find_EX is informational (passed to debug/perf). Correctness must not depend on it.

Test Plan:
1. Test configuration: INDEX_LEN=2, WAYS=2, CNT_BITS=2.
2. Cold taken branch: EX PC_EX=0x100, is_br=1, br=1, target=0x200, NPC_Pred_EX=0x104 -> next cycle fail=1, mispred_count=1. Then PC_IF=0x100 -> find=1, jmp=1 (cnt=2), NPC_Pred=0x200.
3. Hysteresis: entry 0x100 at cnt=2; resolve not-taken once -> cnt=1, PC_IF=0x100 gives jmp=0, NPC_Pred=0x104. Resolve taken twice -> cnt=3. Another taken leaves cnt=3 (saturate).
4. Conflict/replacement: taken branches at 0x100, 0x110, 0x120 (all set 0) -> 0x100 in way0, 0x110 in way1, 0x120 evicts way0 (rr 0->1). PC_IF=0x100 -> find=0; 0x110 and 0x120 -> find=1.
5. Alias invalidation and bubble: entry at 0x100, EX PC_EX=0x100 with is_br=0, NPC_Pred_EX=0x200 -> fail=1, entry invalidated. Same stimulus with ex_valid=0 -> fail=0, entry kept, counters unchanged.
6. Async reset mid-run: drop rst_n between edges with populated table -> find=0, fail=0, br_count=0, mispred_count=0 immediately, without waiting for a clock edge.
